// File: rtl/mmuart_pkg.sv
// Shared constants, encodings and helpers for the mmuart_px UART.
package mmuart_pkg;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SAMPLE_0   = 4'd7;
    localparam logic [3:0] SAMPLE_1   = 4'd8;
    localparam logic [3:0] SAMPLE_2   = 4'd9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } par_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAITHI
    } rx_state_e;

    // Number of data bits in a frame: 5 + cfg_len, never more than the datapath width.
    function automatic logic [3:0] frame_len(input logic [1:0] cfg_len, input logic [3:0] max_len);
        logic [3:0] len;
        len = 4'd5 + {2'b00, cfg_len};
        return (len > max_len) ? max_len : len;
    endfunction

    // The reserved encoding behaves like "no parity".
    function automatic logic parity_on(input par_mode_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/mmuart_baudgen.sv
// Divisor counter producing the 16x oversampling enable shared by TX and RX.
module mmuart_baudgen
    import mmuart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor,
    output logic             enable16
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Count down; on reaching zero fire one enable and reload from the current divisor.
    always_comb begin
        enable16 = (cnt_q == '0);
        if (enable16) begin
            cnt_d = (divisor == '0) ? '0 : divisor - DIV_W'(1);
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Counter register; clearing to zero makes the first tick land right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmuart_px.sv
// Full-duplex UART with 16x oversampling and runtime frame format selection.
module mmuart_px
    import mmuart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_rx,
    output logic              uart_tx,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [1:0]        cfg_len,
    input  logic [1:0]        cfg_par,
    input  logic              cfg_stop2,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_frame_err,
    output logic              rx_par_err,
    output logic              rx_break
);

    logic       enable16;
    logic [2:0] cfg_last;

    mmuart_baudgen #(.DIV_W(DIV_W)) u_baudgen (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .divisor  (divisor),
        .enable16 (enable16)
    );

    assign cfg_last = 3'(frame_len(cfg_len, 4'(DATA_W)) - 4'd1);

    // ---------------- transmitter ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [3:0]        tx_tick_q, tx_tick_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [2:0]        tx_last_q, tx_last_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    par_mode_e         tx_par_q, tx_par_d;
    logic              tx_stop2_q, tx_stop2_d;
    logic              tx_acc_q, tx_acc_d;
    logic              tx_second_q, tx_second_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_bit_end;

    // TX next state: the line level is registered, so each transition also picks the next bit value.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_last_d   = tx_last_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_stop2_d  = tx_stop2_q;
        tx_acc_d    = tx_acc_q;
        tx_second_d = tx_second_q;
        tx_line_d   = tx_line_q;
        tx_done_d   = 1'b0;
        tx_bit_end  = enable16 && (tx_tick_q == TICK_LAST);

        if (enable16 && (tx_state_q != TX_IDLE)) begin
            tx_tick_d = tx_tick_q + 4'd1;
        end

        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (tx_wr) begin
                    tx_state_d  = TX_START;
                    tx_line_d   = 1'b0;
                    tx_tick_d   = 4'd0;
                    tx_bit_d    = 3'd0;
                    tx_shift_d  = tx_data;
                    tx_last_d   = cfg_last;
                    tx_par_d    = par_mode_e'(cfg_par);
                    tx_stop2_d  = cfg_stop2;
                    tx_acc_d    = 1'b0;
                    tx_second_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_line_d  = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_acc_d   = tx_acc_q ^ tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == tx_last_q) begin
                        if (parity_on(tx_par_q)) begin
                            tx_state_d = TX_PARITY;
                            tx_line_d  = tx_acc_q ^ tx_shift_q[0] ^ (tx_par_q == PAR_ODD);
                        end else begin
                            tx_state_d  = TX_STOP;
                            tx_line_d   = 1'b1;
                            tx_second_d = 1'b0;
                        end
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_line_d = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d  = TX_STOP;
                    tx_line_d   = 1'b1;
                    tx_second_d = 1'b0;
                end
            end
            TX_STOP: begin
                tx_line_d = 1'b1;
                if (tx_bit_end) begin
                    if (tx_stop2_q && !tx_second_q) begin
                        tx_second_d = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // TX state register; reset forces the line idle high and drops any frame in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_tick_q   <= 4'd0;
            tx_bit_q    <= 3'd0;
            tx_last_q   <= 3'd0;
            tx_shift_q  <= '0;
            tx_par_q    <= PAR_NONE;
            tx_stop2_q  <= 1'b0;
            tx_acc_q    <= 1'b0;
            tx_second_q <= 1'b0;
            tx_line_q   <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_last_q   <= tx_last_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_stop2_q  <= tx_stop2_d;
            tx_acc_q    <= tx_acc_d;
            tx_second_q <= tx_second_d;
            tx_line_q   <= tx_line_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign uart_tx = tx_line_q;
    assign tx_busy = (tx_state_q != TX_IDLE);
    assign tx_done = tx_done_q;

    // ---------------- receiver ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic              rx_sync1_q, rx_sync1_d;
    logic              rx_sync2_q, rx_sync2_d;
    logic [3:0]        rx_tick_q, rx_tick_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [2:0]        rx_last_q, rx_last_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    par_mode_e         rx_par_q, rx_par_d;
    logic              rx_acc_q, rx_acc_d;
    logic              rx_ones_q, rx_ones_d;
    logic              rx_bad_q, rx_bad_d;
    logic              rx_s0_q, rx_s0_d;
    logic              rx_s1_q, rx_s1_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_ferr_q, rx_ferr_d;
    logic              rx_perr_q, rx_perr_d;
    logic              rx_brk_q, rx_brk_d;
    logic              rx_s, rx_maj, rx_decide, rx_bit_end;

    // RX next state: three mid-bit samples, majority decided on the last one, bit closes at tick 15.
    always_comb begin
        rx_sync1_d = uart_rx;
        rx_sync2_d = rx_sync1_q;
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_last_d  = rx_last_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_acc_d   = rx_acc_q;
        rx_ones_d  = rx_ones_q;
        rx_bad_d   = rx_bad_q;
        rx_s0_d    = rx_s0_q;
        rx_s1_d    = rx_s1_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_perr_d  = 1'b0;
        rx_brk_d   = 1'b0;

        rx_s       = rx_sync2_q;
        rx_maj     = (rx_s0_q & rx_s1_q) | (rx_s0_q & rx_s) | (rx_s1_q & rx_s);
        rx_decide  = enable16 && (rx_tick_q == SAMPLE_2);
        rx_bit_end = enable16 && (rx_tick_q == TICK_LAST);

        if (enable16) begin
            rx_tick_d = rx_tick_q + 4'd1;
        end
        if (enable16 && (rx_tick_q == SAMPLE_0)) begin
            rx_s0_d = rx_s;
        end
        if (enable16 && (rx_tick_q == SAMPLE_1)) begin
            rx_s1_d = rx_s;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (enable16 && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = 4'd0;
                    rx_bit_d   = 3'd0;
                    rx_shift_d = '0;
                    rx_last_d  = cfg_last;
                    rx_par_d   = par_mode_e'(cfg_par);
                    rx_acc_d   = 1'b0;
                    rx_ones_d  = 1'b0;
                    rx_bad_d   = 1'b0;
                end
            end
            RX_START: begin
                if (rx_decide && rx_maj) begin
                    rx_state_d = RX_IDLE;
                end else if (rx_bit_end) begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_decide) begin
                    rx_shift_d[rx_bit_q] = rx_maj;
                    rx_acc_d             = rx_acc_q ^ rx_maj;
                    rx_ones_d            = rx_ones_q | rx_maj;
                end
                if (rx_bit_end) begin
                    if (rx_bit_q == rx_last_q) begin
                        rx_state_d = parity_on(rx_par_q) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_decide) begin
                    rx_bad_d  = rx_maj ^ rx_acc_q ^ (rx_par_q == PAR_ODD);
                    rx_ones_d = rx_ones_q | rx_maj;
                end
                if (rx_bit_end) begin
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_decide) begin
                    rx_done_d  = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_ferr_d  = !rx_maj;
                    rx_perr_d  = rx_bad_q;
                    rx_brk_d   = !rx_maj && !rx_ones_q;
                    rx_state_d = rx_maj ? RX_IDLE : RX_WAITHI;
                end
            end
            RX_WAITHI: begin
                if (enable16 && rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX state register; synchronizers reset to the idle line level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_last_q  <= 3'd0;
            rx_shift_q <= '0;
            rx_par_q   <= PAR_NONE;
            rx_acc_q   <= 1'b0;
            rx_ones_q  <= 1'b0;
            rx_bad_q   <= 1'b0;
            rx_s0_q    <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_brk_q   <= 1'b0;
        end else begin
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_last_q  <= rx_last_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_acc_q   <= rx_acc_d;
            rx_ones_q  <= rx_ones_d;
            rx_bad_q   <= rx_bad_d;
            rx_s0_q    <= rx_s0_d;
            rx_s1_q    <= rx_s1_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            rx_brk_q   <= rx_brk_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done      = rx_done_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_par_err   = rx_perr_q;
    assign rx_break     = rx_brk_q;

endmodule
